// File: rtl/count_sequencer_if.sv
// Control/status bundle for count_sequencer.
// The master side (upstream control logic) issues start/stop and the
// programmed phase lengths; the slave side (the sequencer) returns mode
// select, slow tick, handshake status and the two event counters.
interface count_sequencer_if #(
  parameter int CW = 3,
  parameter int LW = 4
);
  logic          start;
  logic          stop;
  logic          loop;
  logic [LW-1:0] len_f;
  logic [LW-1:0] len_s;
  logic [1:0]    x;
  logic          tick_s;
  logic          busy;
  logic          done;
  logic [CW-1:0] count_f;
  logic [CW-1:0] count_s;

  modport master (
    output start, stop, loop, len_f, len_s,
    input  x, tick_s, busy, done, count_f, count_s
  );

  modport slave (
    input  start, stop, loop, len_f, len_s,
    output x, tick_s, busy, done, count_f, count_s
  );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: single-clock controller for the fast/slow counter pair.
// A free-running prescaler turns clk_f into a one-cycle slow tick (tick_s)
// used as a clock enable, so the slow counter lives in the clk_f domain.
// A run is a FAST phase of len_f clk_f cycles followed by a SLOW phase of
// len_s slow ticks, optionally repeated until stop.
//
// Optional build macro COUNT_SAT_EN: when defined, count_f/count_s saturate
// at their all-ones value instead of wrapping. Phase timing is unaffected.
module count_sequencer #(
  parameter int DIV = 4,
  parameter int CW  = 3,
  parameter int LW  = 4
) (
  input  logic            clk_f,
  input  logic            rst,
  count_sequencer_if.slave bus
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAST = 2'd1,
    SLOW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_cnt;
  logic [LW-1:0] phase_cnt;
  logic [LW-1:0] len_f_q;
  logic [LW-1:0] len_s_q;
  logic          loop_q;
  logic [CW-1:0] count_f_q;
  logic [CW-1:0] count_s_q;
  logic          done_q;
  logic          tick;
  logic [1:0]    x_dec;
  logic          busy_dec;

  // Counter increment; wraps by default, holds at all-ones when saturating.
  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
`ifdef COUNT_SAT_EN
    bump = (v == {CW{1'b1}}) ? v : v + CW'(1);
`else
    bump = v + CW'(1);
`endif
  endfunction

  // Prescaler: free-running 0..DIV-1 in every state, independent of the FSM.
  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Sequencer FSM: latches the program on start, runs FAST then SLOW, and
  // owns the event counters and the one-cycle done pulse.
  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_cnt <= '0;
      len_f_q   <= '0;
      len_s_q   <= '0;
      loop_q    <= 1'b0;
      count_f_q <= '0;
      count_s_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_f_q   <= bus.len_f;
            len_s_q   <= bus.len_s;
            loop_q    <= bus.loop;
            count_f_q <= '0;
            count_s_q <= '0;
            phase_cnt <= '0;
            if (bus.len_f != '0) begin
              state_q <= FAST;
            end else if (bus.len_s != '0) begin
              state_q <= SLOW;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        FAST: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else begin
            count_f_q <= bump(count_f_q);
            if (phase_cnt == len_f_q - LW'(1)) begin
              phase_cnt <= '0;
              if (len_s_q != '0) begin
                state_q <= SLOW;
              end else if (loop_q) begin
                state_q <= FAST;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt + LW'(1);
            end
          end
        end

        SLOW: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else if (tick) begin
            count_s_q <= bump(count_s_q);
            if (phase_cnt == len_s_q - LW'(1)) begin
              phase_cnt <= '0;
              if (loop_q && (len_f_q != '0)) begin
                state_q <= FAST;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt + LW'(1);
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Mode select and busy are pure decodes of the state register.
  always_comb begin
    x_dec    = 2'd2;
    busy_dec = 1'b0;
    case (state_q)
      FAST: begin
        x_dec    = 2'd1;
        busy_dec = 1'b1;
      end
      SLOW: begin
        x_dec    = 2'd0;
        busy_dec = 1'b1;
      end
      default: begin
        x_dec    = 2'd2;
        busy_dec = 1'b0;
      end
    endcase
  end

  assign bus.x       = x_dec;
  assign bus.busy    = busy_dec;
  assign bus.tick_s  = tick;
  assign bus.done    = done_q;
  assign bus.count_f = count_f_q;
  assign bus.count_s = count_s_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Testbench for count_sequencer (DIV=4, CW=3, LW=4).
// Table of single-pass programs with hand-computed counts and busy lengths,
// followed by hand-written sequences for stop, loop, start/stop collision,
// start-while-busy and asynchronous reset.
module tb_count_sequencer;

  localparam int DIV = 4;
  localparam int CW  = 3;
  localparam int LW  = 4;

  typedef struct {
    logic [LW-1:0] len_f;
    logic [LW-1:0] len_s;
    int            exp_cf;
    int            exp_cs;
    int            exp_busy;
  } vec_t;

  logic clk_f;
  logic rst;
  int   tests_run;
  int   tests_failed;
  vec_t vecs [8];

  count_sequencer_if #(.CW(CW), .LW(LW)) bus ();

  count_sequencer #(.DIV(DIV), .CW(CW), .LW(LW)) dut (
    .clk_f (clk_f),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk_f = 1'b0;
    forever #5 clk_f = ~clk_f;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Wait (at a negedge) until tick_s is high so the start edge is also the
  // prescaler wrap edge, then pulse start for one cycle.
  task automatic applyStimulus(input logic [LW-1:0] lf, input logic [LW-1:0] ls, input logic lp);
    int n;
    n = 0;
    while (!bus.tick_s && n < 2 * DIV) begin
      @(negedge clk_f);
      n++;
    end
    checkOutput("align_tick", int'(bus.tick_s), 1);
    bus.len_f = lf;
    bus.len_s = ls;
    bus.loop  = lp;
    bus.start = 1'b1;
    @(negedge clk_f);
    bus.start = 1'b0;
  endtask

  task automatic runVector(input int i);
    int  busy_cnt;
    bit  finished;
    busy_cnt = 0;
    finished = 0;
    applyStimulus(vecs[i].len_f, vecs[i].len_s, 1'b0);
    for (int c = 0; c < 200 && !finished; c++) begin
      if (bus.done) begin
        finished = 1;
      end else begin
        if (bus.busy) busy_cnt++;
        @(negedge clk_f);
      end
    end
    checkOutput($sformatf("v%0d_done_seen", i), int'(finished), 1);
    checkOutput($sformatf("v%0d_x_in_done", i), int'(bus.x), 2);
    checkOutput($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
    checkOutput($sformatf("v%0d_count_f", i), int'(bus.count_f), vecs[i].exp_cf);
    checkOutput($sformatf("v%0d_count_s", i), int'(bus.count_s), vecs[i].exp_cs);
    @(negedge clk_f);
    checkOutput($sformatf("v%0d_done_width", i), int'(bus.done), 0);
    checkOutput($sformatf("v%0d_x_after", i), int'(bus.x), 2);
    checkOutput($sformatf("v%0d_busy_after", i), int'(bus.busy), 0);
    checkOutput($sformatf("v%0d_count_f_hold", i), int'(bus.count_f), vecs[i].exp_cf);
  endtask

  initial begin
    int  dn;
    int  c;
    tests_run    = 0;
    tests_failed = 0;

`ifdef COUNT_SAT_EN
    vecs[0] = '{4'd5,  4'd2,  5, 2, 12};
    vecs[1] = '{4'd10, 4'd0,  7, 0, 10};
    vecs[2] = '{4'd0,  4'd0,  0, 0, 0};
    vecs[3] = '{4'd0,  4'd3,  0, 3, 12};
    vecs[4] = '{4'd3,  4'd1,  3, 1, 4};
    vecs[5] = '{4'd4,  4'd1,  4, 1, 8};
    vecs[6] = '{4'd15, 4'd15, 7, 7, 72};
    vecs[7] = '{4'd9,  4'd0,  7, 0, 9};
`else
    vecs[0] = '{4'd5,  4'd2,  5, 2, 12};
    vecs[1] = '{4'd10, 4'd0,  2, 0, 10};
    vecs[2] = '{4'd0,  4'd0,  0, 0, 0};
    vecs[3] = '{4'd0,  4'd3,  0, 3, 12};
    vecs[4] = '{4'd3,  4'd1,  3, 1, 4};
    vecs[5] = '{4'd4,  4'd1,  4, 1, 8};
    vecs[6] = '{4'd15, 4'd15, 7, 7, 72};
    vecs[7] = '{4'd9,  4'd0,  1, 0, 9};
`endif

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    bus.len_f = '0;
    bus.len_s = '0;

    // Reset state
    #12;
    checkOutput("rst_x", int'(bus.x), 2);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_tick", int'(bus.tick_s), 0);
    checkOutput("rst_count_f", int'(bus.count_f), 0);
    checkOutput("rst_count_s", int'(bus.count_s), 0);
    @(negedge clk_f);
    rst = 1'b0;
    @(negedge clk_f);

    // Table-driven single-pass programs
    for (int i = 0; i < 8; i++) begin
      runVector(i);
    end

    // Stop on the third FAST cycle
    applyStimulus(4'd6, 4'd2, 1'b0);
    @(negedge clk_f);
    @(negedge clk_f);
    bus.stop = 1'b1;
    @(negedge clk_f);
    bus.stop = 1'b0;
    checkOutput("stop_x", int'(bus.x), 2);
    checkOutput("stop_busy", int'(bus.busy), 0);
    checkOutput("stop_count_f", int'(bus.count_f), 2);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.done) dn++;
      @(negedge clk_f);
    end
    checkOutput("stop_no_done", dn, 0);

    // Looping FAST(2) -> SLOW(1 tick), stopped after three iterations
    applyStimulus(4'd2, 4'd1, 1'b1);
    checkOutput("loop_x_f1", int'(bus.x), 1);
    @(negedge clk_f);
    checkOutput("loop_x_f2", int'(bus.x), 1);
    @(negedge clk_f);
    checkOutput("loop_x_s", int'(bus.x), 0);
    dn = 0;
    c  = 0;
    while (bus.count_s != 3'd3 && c < 100) begin
      if (bus.done) dn++;
      @(negedge clk_f);
      c++;
    end
    checkOutput("loop_count_s", int'(bus.count_s), 3);
    checkOutput("loop_count_f", int'(bus.count_f), 6);
    checkOutput("loop_x_refast", int'(bus.x), 1);
    bus.stop = 1'b1;
    @(negedge clk_f);
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    checkOutput("loop_stop_x", int'(bus.x), 2);
    checkOutput("loop_stop_busy", int'(bus.busy), 0);
    checkOutput("loop_stop_count_f", int'(bus.count_f), 6);
    checkOutput("loop_stop_count_s", int'(bus.count_s), 3);
    checkOutput("loop_no_done", dn + int'(bus.done), 0);

    // Start and stop together in IDLE (start wins), then start while busy
    bus.stop = 1'b1;
    applyStimulus(4'd3, 4'd0, 1'b0);
    bus.stop = 1'b0;
    checkOutput("startstop_x", int'(bus.x), 1);
    bus.len_f = 4'd9;
    bus.start = 1'b1;
    @(negedge clk_f);
    bus.start = 1'b0;
    c = 0;
    while (!bus.done && c < 50) begin
      @(negedge clk_f);
      c++;
    end
    checkOutput("busy_start_done", int'(bus.done), 1);
    checkOutput("busy_start_count_f", int'(bus.count_f), 3);
    @(negedge clk_f);

    // Asynchronous reset mid-SLOW, then prescaler period after release
    applyStimulus(4'd1, 4'd5, 1'b0);
    c = 0;
    while (bus.count_s != 3'd1 && c < 50) begin
      @(negedge clk_f);
      c++;
    end
    checkOutput("pre_rst_count_s", int'(bus.count_s), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_x", int'(bus.x), 2);
    checkOutput("arst_busy", int'(bus.busy), 0);
    checkOutput("arst_done", int'(bus.done), 0);
    checkOutput("arst_tick", int'(bus.tick_s), 0);
    checkOutput("arst_count_f", int'(bus.count_f), 0);
    checkOutput("arst_count_s", int'(bus.count_s), 0);
    @(negedge clk_f);
    @(negedge clk_f);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_f);
      checkOutput($sformatf("tick_period_%0d", k), int'(bus.tick_s), ((k % DIV) == DIV - 2) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Single-clock controller for the fast/slow counter pair. It replaces the derived slow clock with a clock-enable tick (`tick_s`) generated from `clk_f`. It drives the mode select `x` and runs a programmed sequence: a fast phase of `len_f` clk_f cycles, then a slow phase of `len_s` slow ticks. The sequence can optionally loop. Start, stop, busy and done give upstream control logic a simple handshake.

Parameters:
- DIV, 4, slow tick period in clk_f cycles (must be ≥2)
- CW, 3, width of count_f / count_s
- LW, 4, width of phase length inputs len_f / len_s

Ports:
- clk_f  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  start request pulse; sampled only in IDLE
- stop  in  1  abort request; honoured in FAST/SLOW
- loop  in  1  repeat FAST→SLOW until stopped; latched at start
- len_f  in  LW  fast phase length in clk_f cycles; latched at start
- len_s  in  LW  slow phase length in slow ticks; latched at start
- x  out  2  mode select: 2'd1 = FAST, 2'd0 = SLOW, 2'd2 = idle/done
- tick_s  out  1  slow clock-enable, one clk_f cycle wide
- busy  out  1  high in FAST or SLOW
- done  out  1  one-cycle pulse on normal sequence completion
- count_f  out  CW  fast event counter
- count_s  out  CW  slow event counter

Behaviour:
- Reset (asynchronous): state=IDLE, div_cnt=0, phase_cnt=0, count_f=0, count_s=0, done=0, busy=0, x=2'd2, tick_s=0.
- Prescaler:
  - div_cnt counts 0..DIV-1 and wraps; it free-runs in every state.
  - tick_s = (div_cnt == DIV-1), combinational from the register. Period is DIV cycles.
- States: IDLE, FAST, SLOW, DONE. `x` and `busy` decode from the state register only.
- IDLE:
  - On start=1: latch len_f, len_s and loop; clear count_f, count_s and phase_cnt.
  - Next state is FAST if len_f≠0, else SLOW if len_s≠0, else DONE.
  - start=0: stay in IDLE; counts hold.
- FAST:
  - Every cycle: count_f++ and phase_cnt++.
  - On the cycle where phase_cnt == len_f_q-1: clear phase_cnt and go to SLOW if len_s_q≠0.
  - If len_s_q=0, go to FAST again when loop_q=1, otherwise to DONE.
  - FAST lasts exactly len_f_q cycles.
- SLOW:
  - On each cycle with tick_s=1: count_s++ and phase_cnt++.
  - On the tick where phase_cnt == len_s_q-1: clear phase_cnt and go to FAST if loop_q=1 (and len_f_q≠0), otherwise to DONE.
  - A tick coinciding with the entry edge into SLOW is not counted.
- DONE: done=1 for this single cycle; go to IDLE unconditionally. Counts hold their final values.
- stop:
  - In FAST or SLOW, go to IDLE next cycle; counts hold; done is not asserted.
  - stop has priority over phase completion and over the increment in that cycle.
  - stop is ignored in IDLE and DONE.
- start while busy or in DONE: ignored.
- Counter width: count_f and count_s wrap modulo 2^CW (7→0 for CW=3).
- Looping: counters are not cleared between loop iterations.
- Simultaneous start and stop in IDLE: start wins.
- Reset mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- COUNT_SAT_EN defined: count_f and count_s saturate at 2^CW-1 instead of wrapping. Phase timing is unchanged.
- COUNT_SAT_EN undefined: modulo-2^CW wrap.

Test Plan:
- DIV=4, len_f=5, len_s=2, loop=0, start pulse at edge k:
  - x=1 on edges k+1..k+5, then count_f=5 and x=0.
  - count_s=2 after two tick_s pulses in SLOW.
  - done high for exactly one cycle, then x=2 and busy=0.
- len_f=10, len_s=0, CW=3: count_f ends at 2 without COUNT_SAT_EN and at 7 with it; done pulses right after FAST.
- len_f=0, len_s=0: start → DONE next cycle with done=1 → IDLE; count_f=0, count_s=0.
- len_f=6, stop asserted on the 3rd FAST cycle: IDLE next cycle, count_f=2, no done pulse, x=2.
- loop=1, len_f=2, len_s=1:
  - x pattern repeats FAST(2 cycles) → SLOW(1 tick).
  - After 3 iterations count_f=6, count_s=3; stop → IDLE.
- rst asserted asynchronously mid-SLOW with count_s=1: all outputs return to reset values immediately; tick_s resumes with a DIV-cycle period after rst drops.
